// File: rtl/var_len_packer.sv
// Variable-length code packer: merges LANES left-justified codes per beat
// into an MSB-first accumulator and emits fixed-width words, with flush.
module var_len_packer #(
    parameter int LANES         = 2,
    parameter int DATA_IN_WIDTH = 32,
    parameter int LEN_IN_WIDTH  = 8,
    parameter int OUT_WIDTH     = 64,
    parameter int FILL_WIDTH    = $clog2(OUT_WIDTH + LANES * DATA_IN_WIDTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*DATA_IN_WIDTH-1:0]   in_data,
    input  logic [LANES*LEN_IN_WIDTH-1:0]    in_len,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [FILL_WIDTH-1:0]            out_len,
    output logic                             out_last,
    output logic                             flush_done
);

    localparam int BEAT_W    = LANES * DATA_IN_WIDTH;
    localparam int ACC_WIDTH = OUT_WIDTH + BEAT_W;
    localparam logic [FILL_WIDTH-1:0] OUT_W_F = FILL_WIDTH'(OUT_WIDTH);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [FILL_WIDTH-1:0]   fill_q, fill_d;
    logic                    out_valid_q, out_valid_d;
    logic [FILL_WIDTH-1:0]   out_len_q, out_len_d;
    logic                    out_last_q, out_last_d;
    logic                    flush_done_q, flush_done_d;

    logic [FILL_WIDTH-1:0]    lane_len  [LANES];
    logic [DATA_IN_WIDTH-1:0] lane_code [LANES];
    logic [BEAT_W-1:0]        beat_data;
    logic [FILL_WIDTH-1:0]    beat_len;
    logic                     push;
    logic                     pop;

    // Clamp each length and zero the bits below the code.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LEN_IN_WIDTH-1:0] len_raw;
        assign len_raw = in_len[i*LEN_IN_WIDTH +: LEN_IN_WIDTH];
        assign lane_len[i] = (int'(len_raw) > DATA_IN_WIDTH)
                           ? FILL_WIDTH'(DATA_IN_WIDTH)
                           : FILL_WIDTH'(len_raw);
        assign lane_code[i] = in_data[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]
                            & ~({DATA_IN_WIDTH{1'b1}} >> lane_len[i]);
    end

    always_comb begin
        beat_data = '0;
        beat_len  = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_data = beat_data
                      | ((BEAT_W'(lane_code[i]) << (BEAT_W - DATA_IN_WIDTH))
                         >> beat_len);
            beat_len  = beat_len + lane_len[i];
        end
    end

    assign in_ready = (state_q == RUN) && ((fill_q < OUT_W_F) || out_ready);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        flush_done_d = 1'b0;
        // Pop first so a concurrent push lands just behind the remainder.
        if (pop) begin
            acc_d  = acc_q << OUT_WIDTH;
            fill_d = (fill_q >= OUT_W_F) ? fill_q - OUT_W_F : '0;
        end
        if (push) begin
            acc_d  = acc_d | ((ACC_WIDTH'(beat_data) << OUT_WIDTH) >> fill_d);
            fill_d = fill_d + beat_len;
        end
        unique case (state_q)
            RUN: begin
                if (!in_valid && flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (fill_q == '0) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        out_valid_d = (fill_d >= OUT_W_F)
                    || ((state_d == FLUSH) && (fill_d != '0));
        out_last_d  = out_valid_d && (fill_d < OUT_W_F);
        out_len_d   = (fill_d >= OUT_W_F) ? OUT_W_F
                    : (out_valid_d ? fill_d : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            out_len_q    <= '0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            out_valid_q  <= out_valid_d;
            out_len_q    <= out_len_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
    assign out_len    = out_len_q;
    assign out_last   = out_last_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_var_len_packer.sv
// Directed bench for var_len_packer at default parameters.
module tb_var_len_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [15:0] in_len = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [7:0]  out_len;
    logic        out_last;
    logic        flush_done;

    int n_vec = 0;
    int n_err = 0;

    var_len_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_last  (out_last),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d0, input logic [7:0] l0,
                       input logic [31:0] d1, input logic [7:0] l1);
        in_valid = 1'b1;
        in_data  = {d1, d0};
        in_len   = {l1, l0};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic word(input string tag, input logic [63:0] d,
                        input logic [7:0] len, input logic last);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"}, out_data, d);
        check({tag, ".len"}, 64'(out_len), 64'(len));
        check({tag, ".last"}, 64'(out_last), 64'(last));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [63:0] held;

    initial begin
        #3;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", out_data, 64'd0);
        check("rst.len", 64'(out_len), 64'd0);
        check("rst.last", 64'(out_last), 64'd0);
        check("rst.done", 64'(flush_done), 64'd0);
        check("rst.ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();

        // basic pack
        put(32'hA000_0000, 8'd4, 32'h5000_0000, 8'd4);
        check("bp.novalid", 64'(out_valid), 64'd0);
        put(32'hFFFF_FFFF, 8'd32, 32'h1234_56FF, 8'd24);
        word("bp", 64'hA5FF_FFFF_FF12_3456, 8'd64, 1'b0);
        pop_one();
        check("bp.drained", 64'(out_valid), 64'd0);

        // clamp, zero length, masking
        put(32'h8000_0001, 8'd40, 32'hFFFF_FFFF, 8'd0);
        check("clamp.novalid", 64'(out_valid), 64'd0);
        put(32'h7FFF_FFFF, 8'd4, 32'h1234_567F, 8'd28);
        word("clamp", 64'h8000_0001_7123_4567, 8'd64, 1'b0);
        pop_one();

        // backpressure then pop+push in one cycle
        put(32'h0123_4567, 8'd32, 32'h89AB_CDEF, 8'd32);
        held = out_data;
        in_valid = 1'b1;
        in_data  = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        in_len   = {8'd32, 8'd32};
        for (int i = 0; i < 5; i++) begin
            check("bkp.ready", 64'(in_ready), 64'd0);
            check("bkp.stable", out_data, 64'h0123_4567_89AB_CDEF);
            tick();
        end
        check("bkp.held", out_data, held);
        out_ready = 1'b1;
        #1;
        check("bkp.ready1", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        word("bkp.next", 64'hDEAD_BEEF_CAFE_F00D, 8'd64, 1'b0);
        pop_one();
        check("bkp.drained", 64'(out_valid), 64'd0);

        // pop with remainder, push appends after the leftover 40 bits
        put(32'hAAAA_AAAA, 8'd32, 32'hBBBB_BBBB, 8'd8);
        put(32'hCCCC_CCCC, 8'd32, 32'hDDDD_DDDD, 8'd32);
        word("pp.w0", 64'hAAAA_AAAA_BBCC_CCCC, 8'd64, 1'b0);
        in_valid  = 1'b1;
        in_data   = {32'h0, 32'h1234_5678};
        in_len    = {8'd0, 8'd24};
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        word("pp.w1", 64'hCCDD_DDDD_DD12_3456, 8'd64, 1'b0);
        pop_one();
        check("pp.drained", 64'(out_valid), 64'd0);

        // flush with 76 bits pending
        put(32'h0123_4567, 8'd32, 32'h89AB_CDEF, 8'd12);
        put(32'hBCDE_FFED, 8'd32, 32'h0, 8'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl.ready0", 64'(in_ready), 64'd0);
        word("fl.full", 64'h0123_4567_89AB_CDEF, 8'd64, 1'b0);
        out_ready = 1'b1;
        tick();
        word("fl.part", 64'hFED0_0000_0000_0000, 8'd12, 1'b1);
        check("fl.ready1", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        check("fl.empty", 64'(out_valid), 64'd0);
        check("fl.nodone", 64'(flush_done), 64'd0);
        check("fl.ready2", 64'(in_ready), 64'd0);
        tick();
        check("fl.done", 64'(flush_done), 64'd1);
        check("fl.ready3", 64'(in_ready), 64'd1);
        tick();
        check("fl.done0", 64'(flush_done), 64'd0);

        // empty flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ef.valid", 64'(out_valid), 64'd0);
        check("ef.nodone", 64'(flush_done), 64'd0);
        check("ef.ready0", 64'(in_ready), 64'd0);
        tick();
        check("ef.done", 64'(flush_done), 64'd1);
        check("ef.valid1", 64'(out_valid), 64'd0);
        check("ef.ready1", 64'(in_ready), 64'd1);
        tick();
        check("ef.done0", 64'(flush_done), 64'd0);

        // reset with 40 bits pending
        put(32'hFFFF_FFFF, 8'd32, 32'hFF00_0000, 8'd8);
        check("mr.pending", out_data, 64'hFFFF_FFFF_FF00_0000);
        #2;
        reset = 1'b0;
        #1;
        check("mr.data", out_data, 64'd0);
        check("mr.valid", 64'(out_valid), 64'd0);
        check("mr.len", 64'(out_len), 64'd0);
        check("mr.ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        put(32'h1111_1111, 8'd32, 32'h2222_2222, 8'd32);
        word("mr.clean", 64'h1111_1111_2222_2222, 8'd64, 1'b0);
        pop_one();
        check("mr.drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/var_len_packer.md
# var_len_packer

Parameterised successor to the two-lane variable-length merger. The block accepts LANES variable-length codes per beat and packs them MSB-first into a bit accumulator. It emits fixed OUT_WIDTH-bit words on a valid/ready stream, and supports an explicit flush that drains a zero-padded partial final word. It sits between the per-symbol encoders and the output word FIFO of the compression path.

## Interface
- LANES, 2: codes accepted per beat.
- DATA_IN_WIDTH, 32: bits per lane slot.
- LEN_IN_WIDTH, 8: bits per lane length field.
- OUT_WIDTH, 64: output word width. Constraint: LANES*DATA_IN_WIDTH ≤ OUT_WIDTH.
- FILL_WIDTH, $clog2(OUT_WIDTH+LANES*DATA_IN_WIDTH+1): width of the fill counter and of out_len.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_IN_WIDTH  lane i occupies [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- in_len  in  LANES*LEN_IN_WIDTH  lane i length at [i*LEN_IN_WIDTH +: LEN_IN_WIDTH].
- flush  in  1  request to drain the accumulator.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_WIDTH  packed word; the first bit in the stream is the MSB.
- out_len  out  FILL_WIDTH  valid bits in out_data: OUT_WIDTH, or the partial count on the last word.
- out_last  out  1  marks the flush-drained partial word.
- flush_done  out  1  one-cycle pulse when the flush completes.

## Operation
- **Lane code format**
  - Each lane code is left-justified: the valid bits are [DATA_IN_WIDTH-1 -: len], and bits below are masked to 0.
  - len > DATA_IN_WIDTH is clamped to DATA_IN_WIDTH.
  - len = 0 contributes nothing.
- **Merge order:** lane 0 first, then lane 1, and so on. Beat length is the sum of the clamped lens.
- **Accumulator**
  - ACC_WIDTH = OUT_WIDTH + LANES*DATA_IN_WIDTH. Data is MSB-aligned. fill is the count of valid bits.
  - Invariant: fill ≤ OUT_WIDTH-1+LANES*DATA_IN_WIDTH.
- **States:** RUN and FLUSH.
- **RUN**
  - in_ready = (fill < OUT_WIDTH) || out_ready.
  - out_valid = (fill ≥ OUT_WIDTH). out_data = acc[ACC_WIDTH-1 -: OUT_WIDTH], out_len = OUT_WIDTH, out_last = 0.
  - Push: append the merged beat at bit position fill; fill += beat length.
  - Pop (out_valid && out_ready): shift acc left by OUT_WIDTH; fill -= OUT_WIDTH.
  - Simultaneous push and pop: the pop is applied first, then the push appends at fill-OUT_WIDTH.
  - flush sampled high with in_valid low: enter FLUSH.
  - flush and in_valid both high: the beat is taken if in_ready, and flush is ignored that cycle. The source holds flush.
- **FLUSH**
  - in_ready = 0.
  - fill ≥ OUT_WIDTH: full words drain as in RUN.
  - 0 < fill < OUT_WIDTH: out_valid = 1, out_data = top fill bits followed by zeros, out_len = fill, out_last = 1. On the handshake fill becomes 0.
  - fill = 0: flush_done pulses for one cycle and the state returns to RUN. An empty flush emits no word.
- Vacated accumulator bits are always zero.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_len=0, out_last=0, flush_done=0, fill=0, acc=0, state RUN. Hence in_ready=1 while and after reset.
- **Reset mid-operation:** any pending bits are discarded immediately.
- **Registered outputs:** out_data, out_len, out_last and flush_done are driven from registers. in_ready is combinational from fill, state and out_ready.
- **Latency:** a beat accepted at edge k that brings fill ≥ OUT_WIDTH gives out_valid=1 in the cycle after edge k.
- **Backpressure:** while out_valid=1 and out_ready=0, out_data, out_len and out_last hold stable, and in_ready=0 if fill ≥ OUT_WIDTH.
- **Throughput:** full rate (one beat per cycle) is sustained whenever out_ready=1.
- **Flush timing:** FLUSH is entered on the edge after the flush sample. flush_done asserts in the cycle after fill reaches 0.

## Test plan
All scenarios use the defaults: LANES=2, DATA_IN_WIDTH=32, OUT_WIDTH=64.
- **Reset:** assert reset mid-stream with fill=40 -> all outputs 0 immediately, in_ready=1; after release, a new 64-bit beat produces an untainted word.
- **Basic pack:** beat {len 4, 0xA0000000; len 4, 0x50000000}, then beat {len 32, 0xFFFFFFFF; len 24, 0x123456FF} -> next cycle out_valid=1, out_data=0xA5FFFFFFFF123456, out_len=64.
- **Mask, clamp, zero-length:** lane0 len 40 with data 0x80000001, lane1 len 0 -> only 32 bits are appended; the trailing bits of a len-4 lane are masked to zero in out_data.
- **Backpressure:** with fill=64, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable; then out_ready=1 together with a 64-bit beat -> pop and push in the same cycle, and the next word appears the following cycle.
- **Flush:** fill=76 (word 0x0123456789ABCDEF followed by 12 bits 0xFED), flush=1 -> full word out, then out_data=0xFED0000000000000, out_len=12, out_last=1, then a flush_done pulse; in_ready=0 throughout.
- **Empty flush:** flush at fill=0 -> no out_valid, flush_done pulses 2 cycles after the flush sample, and in_ready returns to 1.
